// File: rtl/regfile_wr_arbiter.sv
// Regfile write-port owner: clears r1..r31 after reset, then arbitrates between the
// in-order WB stage and a FIFO of long-latency results with starvation relief and squashing.
module regfile_wr_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    output logic        wb_stall,
    input  logic        lu_valid,
    input  logic [4:0]  lu_wa,
    input  logic [31:0] lu_wd,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        init_done,
    output logic [7:0]  squash_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e         state_q;
    logic [4:0]     ptr_q;
    logic [4:0]     fwa_q [DEPTH];
    logic [31:0]    fwd_q [DEPTH];
    logic [DEPTH-1:0] fvld_q, fvld_d;
    logic [AW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [7:0]     squash_q, squash_d;
    logic           rf_we_q, init_done_q;
    logic [4:0]     rf_wa_q;
    logic [31:0]    rf_wd_q;

    logic running, empty, full, force_slot, head_vld, wb_req, push;
    logic pop, issue_wb, issue_fifo;
    logic [DEPTH-1:0] squash_hit;
    logic [8:0]       squash_sum;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [8:0] b);
        logic [9:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s > 10'd255) ? 8'hFF : s[7:0];
    endfunction

    assign running    = (state_q == ST_RUN);
    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == CW'(DEPTH));
    assign force_slot = running & (starve_q == SW'(STARVE_LIMIT));
    assign head_vld   = fvld_q[rd_q];
    assign wb_req     = wb_we & (wb_wa != 5'd0);

    assign wb_stall = ~running | force_slot;
    assign lu_ready = running & ~full;
    // Address-0 results are handshaken but never stored.
    assign push     = lu_valid & lu_ready & (lu_wa != 5'd0);

    // A squashed head is popped without taking the write slot, so WB may still issue.
    always_comb begin
        pop        = 1'b0;
        issue_wb   = 1'b0;
        issue_fifo = 1'b0;
        if (running) begin
            if (force_slot) begin
                pop        = ~empty;
                issue_fifo = ~empty & head_vld;
            end else if (wb_req) begin
                issue_wb = 1'b1;
                pop      = ~empty & ~head_vld;
            end else if (~empty) begin
                pop        = 1'b1;
                issue_fifo = head_vld;
            end
        end
    end

    always_comb begin
        squash_hit = '0;
        squash_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash_hit[i] = issue_wb & fvld_q[i] & (fwa_q[i] == wb_wa);
            squash_sum    = squash_sum + 9'(squash_hit[i]);
        end
    end

    always_comb begin
        fvld_d = fvld_q & ~squash_hit;
        if (pop)  fvld_d[rd_q] = 1'b0;
        if (push) fvld_d[wr_q] = 1'b1;
        rd_d     = rd_q + AW'(pop);
        wr_d     = wr_q + AW'(push);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        squash_d = sat_add8(squash_q, squash_sum);
        if (!running || pop || empty)
            starve_d = '0;
        else if (issue_wb)
            starve_d = starve_q + SW'(1);
        else
            starve_d = starve_q;
    end

    // Stage boundary: control state and the registered regfile write port.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q     <= ST_INIT;
            ptr_q       <= 5'd1;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            fvld_q      <= '0;
            starve_q    <= '0;
            squash_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_wa_q     <= '0;
            rf_wd_q     <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            rf_we_q <= 1'b1;
            rf_wa_q <= ptr_q;
            rf_wd_q <= '0;
            ptr_q   <= ptr_q + 5'd1;
            if (ptr_q == 5'd31) begin
                state_q     <= ST_RUN;
                init_done_q <= 1'b1;
            end
        end else begin
            if (issue_wb) begin
                rf_we_q <= 1'b1;
                rf_wa_q <= wb_wa;
                rf_wd_q <= wb_wd;
            end else if (issue_fifo) begin
                rf_we_q <= 1'b1;
                rf_wa_q <= fwa_q[rd_q];
                rf_wd_q <= fwd_q[rd_q];
            end else begin
                rf_we_q <= 1'b0;
            end
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            fvld_q   <= fvld_d;
            starve_q <= starve_d;
            squash_q <= squash_d;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (push) begin
            fwa_q[wr_q] <= lu_wa;
            fwd_q[wr_q] <= lu_wd;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_wa      = rf_wa_q;
    assign rf_wd      = rf_wd_q;
    assign init_done  = init_done_q;
    assign squash_cnt = squash_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: expected regfile writes are queued as stimulus
// is driven and compared in order whenever the DUT asserts rf_we.
module tb_regfile_wr_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst;
    logic        wb_we, lu_valid;
    logic [4:0]  wb_wa, lu_wa;
    logic [31:0] wb_wd, lu_wd;
    logic        wb_stall, lu_ready, rf_we, init_done;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [7:0]  squash_cnt;

    regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_stall(wb_stall),
        .lu_valid(lu_valid), .lu_wa(lu_wa), .lu_wd(lu_wd), .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .init_done(init_done), .squash_cnt(squash_cnt)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] wa, input logic [31:0] wd);
        sb.push_back({wa, wd});
    endtask

    task automatic idle_inputs();
        wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        lu_valid = 1'b0; lu_wa = '0; lu_wd = '0;
    endtask

    // Every issued write must match the oldest expected one.
    always @(negedge cpu_clk_50M) begin
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty_on_write", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("rf_write", 64'({rf_wa, rf_wd}), 64'({mon_e.wa, mon_e.wd}));
            end
        end
    end

    task automatic run_init();
        for (int i = 1; i <= 31; i++) expect_wr(5'(i), 32'h0);
        for (int i = 1; i <= 31; i++) begin
            chk("init_stall", 64'(wb_stall), 64'd1);
            chk("init_lu_ready", 64'(lu_ready), 64'd0);
            wb_we = 1'b1; wb_wa = 5'd17; wb_wd = 32'hDEAD0000 + 32'(i);
            lu_valid = 1'b1; lu_wa = 5'd18; lu_wd = 32'hBEEF0000 + 32'(i);
            tick();
            chk("init_we", 64'(rf_we), 64'd1);
            chk("init_done", 64'(init_done), 64'(i == 31));
        end
        idle_inputs();
    endtask

    initial begin
        logic stalled, accepted;
        int   k, j;
        int   exp_rdy [7] = '{1, 1, 0, 0, 0, 0, 1};

        idle_inputs();
        cpu_rst = 1'b1;
        tick();
        tick();
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_wa", 64'(rf_wa), 64'd0);
        chk("rst_rf_wd", 64'(rf_wd), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_squash", 64'(squash_cnt), 64'd0);
        chk("rst_stall", 64'(wb_stall), 64'd1);
        chk("rst_lu_ready", 64'(lu_ready), 64'd0);
        cpu_rst = 1'b0;
        run_init();

        // Single WB write, then a WB request to r0 that must not write.
        chk("run_lu_ready", 64'(lu_ready), 64'd1);
        chk("run_stall", 64'(wb_stall), 64'd0);
        expect_wr(5'd5, 32'hA5A5A5A5);
        wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'hA5A5A5A5;
        tick();
        chk("wb_we", 64'(rf_we), 64'd1);
        wb_wa = 5'd0; wb_wd = 32'h12345678;
        tick();
        chk("wa0_no_write", 64'(rf_we), 64'd0);
        chk("wa0_hold_wd", 64'(rf_wd), 64'hA5A5A5A5);
        idle_inputs();
        tick();
        chk("idle_no_write", 64'(rf_we), 64'd0);
        chk("drain_wb", 64'(sb.size()), 64'd0);

        // Collision: WB on r7 every cycle starves the FIFO head until a forced slot.
        for (int i = 0; i < 5; i++) expect_wr(5'd7, 32'h07000000 + 32'(i));
        expect_wr(5'd3, 32'h11);
        for (int i = 5; i < 7; i++) expect_wr(5'd7, 32'h07000000 + 32'(i));
        k = 0;
        for (int c = 0; c < 8; c++) begin
            chk("col_stall", 64'(wb_stall), 64'(c == 5));
            if (c == 0) chk("col_lu_ready", 64'(lu_ready), 64'd1);
            wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'h07000000 + 32'(k);
            lu_valid = (c == 0); lu_wa = 5'd3; lu_wd = 32'h11;
            stalled = wb_stall;
            tick();
            if (!stalled) k++;
        end
        idle_inputs();
        tick();
        tick();
        chk("drain_col", 64'(sb.size()), 64'd0);

        // Backpressure: three back-to-back results against a 2-entry FIFO with WB busy.
        for (int i = 0; i < 5; i++) expect_wr(5'd8, 32'h08000000 + 32'(i));
        expect_wr(5'd10, 32'hA0);
        expect_wr(5'd8, 32'h08000005);
        expect_wr(5'd11, 32'hA1);
        expect_wr(5'd12, 32'hA2);
        k = 0; j = 0;
        for (int c = 0; c < 9; c++) begin
            if (c <= 6) chk("bp_lu_ready", 64'(lu_ready), 64'(exp_rdy[c]));
            chk("bp_stall", 64'(wb_stall), 64'(c == 5));
            wb_we = (c <= 6); wb_wa = 5'd8; wb_wd = 32'h08000000 + 32'(k);
            lu_valid = (j < 3); lu_wa = 5'(10 + j); lu_wd = 32'hA0 + 32'(j);
            stalled  = wb_stall;
            accepted = lu_valid & lu_ready;
            tick();
            if (!stalled && c <= 6) k++;
            if (accepted) j++;
        end
        chk("bp_pushed", 64'(j), 64'd3);
        idle_inputs();
        tick();
        chk("drain_bp", 64'(sb.size()), 64'd0);

        // Squash: a buffered r9 result is overtaken by a newer WB write to r9.
        chk("pre_squash_cnt", 64'(squash_cnt), 64'd0);
        expect_wr(5'd7, 32'h70);
        expect_wr(5'd9, 32'h33);
        chk("sq_lu_ready", 64'(lu_ready), 64'd1);
        wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'h70;
        lu_valid = 1'b1; lu_wa = 5'd9; lu_wd = 32'h22;
        tick();
        lu_valid = 1'b0;
        wb_wa = 5'd9; wb_wd = 32'h33;
        tick();
        chk("sq_cnt", 64'(squash_cnt), 64'd1);
        idle_inputs();
        tick();
        chk("sq_no_issue", 64'(rf_we), 64'd0);
        tick();
        chk("sq_no_issue2", 64'(rf_we), 64'd0);
        chk("sq_empty", 64'(lu_ready), 64'd1);
        chk("drain_sq", 64'(sb.size()), 64'd0);

        // Same-cycle push to the address WB writes survives.
        expect_wr(5'd4, 32'h40);
        expect_wr(5'd4, 32'h44);
        wb_we = 1'b1; wb_wa = 5'd4; wb_wd = 32'h40;
        lu_valid = 1'b1; lu_wa = 5'd4; lu_wd = 32'h44;
        tick();
        idle_inputs();
        tick();
        chk("same_cycle_cnt", 64'(squash_cnt), 64'd1);
        tick();
        chk("drain_same", 64'(sb.size()), 64'd0);

        // Result for r0 is accepted but never written.
        chk("r0_lu_ready", 64'(lu_ready), 64'd1);
        lu_valid = 1'b1; lu_wa = 5'd0; lu_wd = 32'h55;
        tick();
        idle_inputs();
        tick();
        chk("r0_no_write", 64'(rf_we), 64'd0);
        tick();
        chk("r0_no_write2", 64'(rf_we), 64'd0);
        chk("r0_lu_ready2", 64'(lu_ready), 64'd1);

        // Reset with two buffered results: they vanish and INIT restarts at r1.
        expect_wr(5'd6, 32'h06000000);
        expect_wr(5'd6, 32'h06000001);
        wb_we = 1'b1; wb_wa = 5'd6; wb_wd = 32'h06000000;
        lu_valid = 1'b1; lu_wa = 5'd13; lu_wd = 32'hD0;
        tick();
        chk("mid_lu_ready", 64'(lu_ready), 64'd1);
        wb_wd = 32'h06000001; lu_wa = 5'd14; lu_wd = 32'hD1;
        tick();
        chk("mid_full", 64'(lu_ready), 64'd0);
        idle_inputs();
        cpu_rst = 1'b1;
        tick();
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_done", 64'(init_done), 64'd0);
        chk("mid_rst_squash", 64'(squash_cnt), 64'd0);
        chk("mid_rst_stall", 64'(wb_stall), 64'd1);
        chk("drain_mid", 64'(sb.size()), 64'd0);
        cpu_rst = 1'b0;
        run_init();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_idle", 64'(rf_we), 64'd0);
        end
        chk("post_rst_lu_ready", 64'(lu_ready), 64'd1);
        chk("drain_final", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
